q_sys_onchip_ram_2p: RTL and testbench

Q_SYS_ONCHIP_RAM_2P -- requirements
Module: q_sys_onchip_ram_2p

---
 rtl/q_sys_onchip_ram_2p.sv | 150 +++++++++++++++
 tb/tb_q_sys_onchip_ram_2p.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/q_sys_onchip_ram_2p.sv
// Two-slave Avalon-MM front end sharing one single-port on-chip RAM.
// Round-robin arbitration, byte-lane writes, tagged read return.
// Optional macro Q_SYS_ONCHIP_RAM_2P_OUTREG_EN adds an output register
// after the array (read latency 2 instead of 1).
module q_sys_onchip_ram_2p #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 9,
  parameter              INIT_FILE = "q_sys_onchip_ram_2p.hex"
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reset_req,
  input  logic                clken,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic                s1_waitrequest,
  input  logic [ADDR_W-1:0]   s2_address,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  input  logic                s2_chipselect,
  input  logic                s2_read,
  input  logic                s2_write,
  input  logic [DATA_W-1:0]   s2_writedata,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid,
  output logic                s2_waitrequest
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned DEPTH = 32'(1) << ADDR_W;

  // The init image is loaded by the device configuration flow, not by logic.
  localparam bit HAS_INIT_IMAGE = |INIT_FILE;
  if (HAS_INIT_IMAGE) begin : g_init_image
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic              req1_c, req2_c, acc_en_c;
  logic              grant1_c, grant2_c;
  logic              acc_rd_c, acc_wr_c, acc_tag_c;
  logic [ADDR_W-1:0] acc_addr_c;
  logic [BE_W-1:0]   acc_be_c;
  logic [DATA_W-1:0] acc_wdata_c, rd_word_c;
  logic              ret_vld_c, ret_tag_c;
  logic [DATA_W-1:0] ret_data_c;

  // last_q = 1 means port 2 was granted last
  logic              last_q, last_d;
  logic              s1_rvalid_q, s1_rvalid_d, s2_rvalid_q, s2_rvalid_d;
  logic [DATA_W-1:0] s1_rdata_q, s1_rdata_d, s2_rdata_q, s2_rdata_d;
`ifdef Q_SYS_ONCHIP_RAM_2P_OUTREG_EN
  logic              pipe_vld_q, pipe_vld_d, pipe_tag_q, pipe_tag_d;
  logic [DATA_W-1:0] pipe_data_q, pipe_data_d;
`endif

  // Request decode, round-robin grant and the single granted array access
  always_comb begin
    req1_c      = s1_chipselect & (s1_read | s1_write);
    req2_c      = s2_chipselect & (s2_read | s2_write);
    acc_en_c    = clken & ~reset_req & ~reset;
    grant1_c    = acc_en_c & req1_c & (~req2_c | last_q);
    grant2_c    = acc_en_c & req2_c & (~req1_c | ~last_q);
    acc_tag_c   = grant2_c;
    acc_addr_c  = grant2_c ? s2_address    : s1_address;
    acc_be_c    = grant2_c ? s2_byteenable : s1_byteenable;
    acc_wdata_c = grant2_c ? s2_writedata  : s1_writedata;
    acc_wr_c    = (grant1_c & s1_write) | (grant2_c & s2_write);
    acc_rd_c    = (grant1_c & s1_read & ~s1_write) | (grant2_c & s2_read & ~s2_write);
    rd_word_c   = mem[acc_addr_c];
    last_d      = last_q;
    if (grant1_c) begin
      last_d = 1'b0;
    end else if (grant2_c) begin
      last_d = 1'b1;
    end
  end

  assign s1_waitrequest = req1_c & ~grant1_c;
  assign s2_waitrequest = req2_c & ~grant2_c;

  // Read return path: optional output stage, then route by tag to one port
  always_comb begin
`ifdef Q_SYS_ONCHIP_RAM_2P_OUTREG_EN
    pipe_vld_d  = acc_rd_c;
    pipe_tag_d  = acc_tag_c;
    pipe_data_d = acc_rd_c ? rd_word_c : pipe_data_q;
    ret_vld_c   = pipe_vld_q;
    ret_tag_c   = pipe_tag_q;
    ret_data_c  = pipe_data_q;
`else
    ret_vld_c   = acc_rd_c;
    ret_tag_c   = acc_tag_c;
    ret_data_c  = rd_word_c;
`endif
    s1_rvalid_d = ret_vld_c & ~ret_tag_c;
    s2_rvalid_d = ret_vld_c & ret_tag_c;
    s1_rdata_d  = s1_rvalid_d ? ret_data_c : s1_rdata_q;
    s2_rdata_d  = s2_rvalid_d ? ret_data_c : s2_rdata_q;
  end

  // Control and return registers; read stages advance regardless of clken
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q      <= 1'b1;
      s1_rvalid_q <= 1'b0;
      s2_rvalid_q <= 1'b0;
      s1_rdata_q  <= '0;
      s2_rdata_q  <= '0;
`ifdef Q_SYS_ONCHIP_RAM_2P_OUTREG_EN
      pipe_vld_q  <= 1'b0;
      pipe_tag_q  <= 1'b0;
      pipe_data_q <= '0;
`endif
    end else begin
      last_q      <= last_d;
      s1_rvalid_q <= s1_rvalid_d;
      s2_rvalid_q <= s2_rvalid_d;
      s1_rdata_q  <= s1_rdata_d;
      s2_rdata_q  <= s2_rdata_d;
`ifdef Q_SYS_ONCHIP_RAM_2P_OUTREG_EN
      pipe_vld_q  <= pipe_vld_d;
      pipe_tag_q  <= pipe_tag_d;
      pipe_data_q <= pipe_data_d;
`endif
    end
  end

  // Array write, byte lanes only; contents survive reset
  always_ff @(posedge clk) begin
    if (acc_wr_c) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (acc_be_c[b]) begin
          mem[acc_addr_c][8*b +: 8] <= acc_wdata_c[8*b +: 8];
        end
      end
    end
  end

  assign s1_readdata      = s1_rdata_q;
  assign s2_readdata      = s2_rdata_q;
  assign s1_readdatavalid = s1_rvalid_q;
  assign s2_readdatavalid = s2_rvalid_q;

endmodule

// File: tb/tb_q_sys_onchip_ram_2p.sv
// Directed table-driven bench for q_sys_onchip_ram_2p (either latency build).
`timescale 1ns/1ps
module tb_q_sys_onchip_ram_2p;

`ifdef Q_SYS_ONCHIP_RAM_2P_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  logic        clk = 1'b0;
  logic        reset, reset_req, clken;
  logic [8:0]  s1_address, s2_address;
  logic [3:0]  s1_byteenable, s2_byteenable;
  logic        s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
  logic [31:0] s1_writedata, s2_writedata, s1_readdata, s2_readdata;
  logic        s1_readdatavalid, s2_readdatavalid, s1_waitrequest, s2_waitrequest;

  always #5 clk = ~clk;

  q_sys_onchip_ram_2p dut (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid), .s1_waitrequest(s1_waitrequest),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
    .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid), .s2_waitrequest(s2_waitrequest)
  );

  typedef struct {
    logic cs1, rd1, wr1; logic [8:0] a1; logic [3:0] be1; logic [31:0] wd1;
    logic cs2, rd2, wr2; logic [8:0] a2; logic [3:0] be2; logic [31:0] wd2;
    logic ck;
    logic ew1, ew2;     // expected waitrequest this cycle
    logic ev1, ev2;     // this cycle's grant returns read data to port 1 / 2
    logic [31:0] ed;    // data that read returns
  } vec_t;

  vec_t vt[$];
  int n_chk = 0;
  int n_pass = 0;

  function automatic vec_t v(
    input logic cs1, rd1, wr1, input logic [8:0] a1, input logic [3:0] be1, input logic [31:0] wd1,
    input logic cs2, rd2, wr2, input logic [8:0] a2, input logic [3:0] be2, input logic [31:0] wd2,
    input logic ck, ew1, ew2, ev1, ev2, input logic [31:0] ed);
    vec_t t;
    t.cs1 = cs1; t.rd1 = rd1; t.wr1 = wr1; t.a1 = a1; t.be1 = be1; t.wd1 = wd1;
    t.cs2 = cs2; t.rd2 = rd2; t.wr2 = wr2; t.a2 = a2; t.be2 = be2; t.wd2 = wd2;
    t.ck = ck; t.ew1 = ew1; t.ew2 = ew2; t.ev1 = ev1; t.ev2 = ev2; t.ed = ed;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input vec_t t);
    s1_chipselect = t.cs1; s1_read = t.rd1; s1_write = t.wr1;
    s1_address = t.a1; s1_byteenable = t.be1; s1_writedata = t.wd1;
    s2_chipselect = t.cs2; s2_read = t.rd2; s2_write = t.wr2;
    s2_address = t.a2; s2_byteenable = t.be2; s2_writedata = t.wd2;
    clken = t.ck;
  endtask

  task automatic idle();
    drive(v(N,N,N,9'h0,4'h0,32'h0, N,N,N,9'h0,4'h0,32'h0, Y, N,N,N,N,32'h0));
  endtask

  task automatic rd1(input logic [8:0] a);
    s1_chipselect = Y; s1_read = Y; s1_write = N; s1_address = a;
  endtask

  task automatic rd2(input logic [8:0] a);
    s2_chipselect = Y; s2_read = Y; s2_write = N; s2_address = a;
  endtask

  // Called just after the grant edge; steps until the valid pulse, bounded
  task automatic wait_rv(input int port, input logic [31:0] exp, input string name);
    int n = 1;
    while (((port == 1) ? s1_readdatavalid : s2_readdatavalid) !== 1'b1 && n < 6) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, " latency"}, 32'(n), 32'(LAT));
    chk({name, " data"}, (port == 1) ? s1_readdata : s2_readdata, exp);
  endtask

  logic        pv1 [2];
  logic        pv2 [2];
  logic [31:0] pd  [2];
  logic [31:0] hd1, hd2;
  logic        r1 [4];
  logic        r2 [4];

  initial begin
    // cs1 rd1 wr1 a1 be1 wd1 | cs2 rd2 wr2 a2 be2 wd2 | ck | ew1 ew2 ev1 ev2 ed
    vt.push_back(v(Y,N,Y,9'h005,4'hF,32'hAABBCCDD, N,N,N,9'h000,4'h0,32'h0, Y, N,N,N,N,32'h0));
    vt.push_back(v(Y,N,Y,9'h005,4'h5,32'h11223344, N,N,N,9'h000,4'h0,32'h0, Y, N,N,N,N,32'h0));
    vt.push_back(v(N,N,N,9'h000,4'h0,32'h0,        Y,Y,N,9'h005,4'h0,32'h0, Y, N,N,N,Y,32'hAA22CC44));
    vt.push_back(v(Y,N,Y,9'h1FF,4'hF,32'hDEADBEEF, N,N,N,9'h000,4'h0,32'h0, Y, N,N,N,N,32'h0));
    vt.push_back(v(N,N,N,9'h000,4'h0,32'h0,        Y,Y,N,9'h1FF,4'h0,32'h0, Y, N,N,N,Y,32'hDEADBEEF));
    vt.push_back(v(Y,N,Y,9'h010,4'hF,32'h01010101, Y,N,Y,9'h020,4'hF,32'h02020202, Y, N,Y,N,N,32'h0));
    vt.push_back(v(N,N,N,9'h000,4'h0,32'h0,        Y,N,Y,9'h020,4'hF,32'h02020202, Y, N,N,N,N,32'h0));
    vt.push_back(v(Y,Y,N,9'h010,4'h0,32'h0,        Y,Y,N,9'h020,4'h0,32'h0, Y, N,Y,Y,N,32'h01010101));
    vt.push_back(v(Y,Y,N,9'h010,4'h0,32'h0,        Y,Y,N,9'h020,4'h0,32'h0, Y, Y,N,N,Y,32'h02020202));
    vt.push_back(v(Y,Y,N,9'h010,4'h0,32'h0,        Y,Y,N,9'h020,4'h0,32'h0, Y, N,Y,Y,N,32'h01010101));
    vt.push_back(v(Y,Y,N,9'h010,4'h0,32'h0,        Y,Y,N,9'h020,4'h0,32'h0, Y, Y,N,N,Y,32'h02020202));
    vt.push_back(v(Y,Y,N,9'h010,4'h0,32'h0,        Y,Y,N,9'h020,4'h0,32'h0, Y, N,Y,Y,N,32'h01010101));
    vt.push_back(v(Y,Y,N,9'h010,4'h0,32'h0,        Y,Y,N,9'h020,4'h0,32'h0, Y, Y,N,N,Y,32'h02020202));
    vt.push_back(v(N,N,N,9'h000,4'h0,32'h0,        N,N,N,9'h000,4'h0,32'h0, Y, N,N,N,N,32'h0));
    vt.push_back(v(Y,Y,Y,9'h030,4'hF,32'h33333333, N,N,N,9'h000,4'h0,32'h0, Y, N,N,N,N,32'h0));
    vt.push_back(v(Y,Y,N,9'h030,4'h0,32'h0,        N,N,N,9'h000,4'h0,32'h0, Y, N,N,Y,N,32'h33333333));
    vt.push_back(v(Y,Y,N,9'h010,4'h0,32'h0,        N,N,N,9'h000,4'h0,32'h0, N, Y,N,N,N,32'h0));
    vt.push_back(v(Y,Y,N,9'h010,4'h0,32'h0,        N,N,N,9'h000,4'h0,32'h0, Y, N,N,Y,N,32'h01010101));
    vt.push_back(v(N,N,N,9'h000,4'h0,32'h0,        N,N,N,9'h000,4'h0,32'h0, N, N,N,N,N,32'h0));
    vt.push_back(v(N,N,N,9'h000,4'h0,32'h0,        Y,N,Y,9'h030,4'h0,32'hFFFFFFFF, Y, N,N,N,N,32'h0));
    vt.push_back(v(Y,Y,N,9'h030,4'h0,32'h0,        N,Y,N,9'h005,4'h0,32'h0, Y, N,N,Y,N,32'h33333333));
    vt.push_back(v(N,N,N,9'h000,4'h0,32'h0,        Y,Y,N,9'h030,4'h0,32'h0, Y, N,N,N,Y,32'h33333333));
    vt.push_back(v(N,N,N,9'h000,4'h0,32'h0,        N,N,N,9'h000,4'h0,32'h0, Y, N,N,N,N,32'h0));
    vt.push_back(v(N,N,N,9'h000,4'h0,32'h0,        N,N,N,9'h000,4'h0,32'h0, Y, N,N,N,N,32'h0));

    // Reset with a request pending: never granted
    reset = 1'b1; reset_req = 1'b0;
    idle();
    rd1(9'h005);
    #1;
    chk("reset wait1", 32'(s1_waitrequest), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid1", 32'(s1_readdatavalid), 32'd0);
    chk("reset valid2", 32'(s2_readdatavalid), 32'd0);
    chk("reset data1", s1_readdata, 32'h0);
    chk("reset data2", s2_readdata, 32'h0);
    reset = 1'b0;

    // Table: one row per cycle; returns checked LAT edges later via a delay line
    for (int k = 0; k < 2; k++) begin pv1[k] = N; pv2[k] = N; pd[k] = 32'h0; end
    hd1 = 32'h0; hd2 = 32'h0;
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i]);
      #1;
      chk($sformatf("row%0d wait1", i), 32'(s1_waitrequest), 32'(vt[i].ew1));
      chk($sformatf("row%0d wait2", i), 32'(s2_waitrequest), 32'(vt[i].ew2));
      @(posedge clk); #1;
      pv1[1] = pv1[0]; pv2[1] = pv2[0]; pd[1] = pd[0];
      pv1[0] = vt[i].ev1; pv2[0] = vt[i].ev2; pd[0] = vt[i].ed;
      if (pv1[LAT-1]) hd1 = pd[LAT-1];
      if (pv2[LAT-1]) hd2 = pd[LAT-1];
      chk($sformatf("row%0d valid1", i), 32'(s1_readdatavalid), 32'(pv1[LAT-1]));
      chk($sformatf("row%0d valid2", i), 32'(s2_readdatavalid), 32'(pv2[LAT-1]));
      chk($sformatf("row%0d data1", i), s1_readdata, hd1);
      chk($sformatf("row%0d data2", i), s2_readdata, hd2);
    end

    // reset_req blocks s1 until it drops
    idle();
    reset_req = 1'b1;
    rd1(9'h010);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("blocked%0d wait1", k), 32'(s1_waitrequest), 32'd1);
      @(posedge clk); #1;
      chk($sformatf("blocked%0d valid1", k), 32'(s1_readdatavalid), 32'd0);
    end
    reset_req = 1'b0;
    #1;
    chk("unblock wait1", 32'(s1_waitrequest), 32'd0);
    @(posedge clk); #1;
    idle();
    wait_rv(1, 32'h01010101, "unblock");
    @(posedge clk); #1;

    // Reset the cycle after an s2 read grant, then a tie
    rd2(9'h005);
    #1;
    chk("pre-reset wait2", 32'(s2_waitrequest), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    rd1(9'h010); rd2(9'h020);
    #1;
    chk("in-reset wait1", 32'(s1_waitrequest), 32'd1);
    chk("in-reset wait2", 32'(s2_waitrequest), 32'd1);
    @(posedge clk); #1;
    chk("midreset valid1", 32'(s1_readdatavalid), 32'd0);
    chk("midreset valid2", 32'(s2_readdatavalid), 32'd0);
    chk("midreset data1", s1_readdata, 32'h0);
    chk("midreset data2", s2_readdata, 32'h0);
    reset = 1'b0;
    idle();
    @(posedge clk); #1;
    chk("discarded valid2", 32'(s2_readdatavalid), 32'd0);
    rd1(9'h005); rd2(9'h1FF);
    #1;
    chk("tie wait1", 32'(s1_waitrequest), 32'd0);
    chk("tie wait2", 32'(s2_waitrequest), 32'd1);
    @(posedge clk); #1;
    r1[0] = s1_readdatavalid; r2[0] = s2_readdatavalid;
    idle(); rd2(9'h1FF);
    #1;
    chk("tie second wait2", 32'(s2_waitrequest), 32'd0);
    @(posedge clk); #1;
    r1[1] = s1_readdatavalid; r2[1] = s2_readdatavalid;
    idle();
    for (int k = 2; k < 4; k++) begin
      @(posedge clk); #1;
      r1[k] = s1_readdatavalid; r2[k] = s2_readdatavalid;
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("tie trace%0d valid1", k), 32'(r1[k]), 32'(k == LAT - 1));
      chk($sformatf("tie trace%0d valid2", k), 32'(r2[k]), 32'(k == LAT));
    end
    chk("tie data1", s1_readdata, 32'hAA22CC44);
    chk("tie data2", s2_readdata, 32'hDEADBEEF);

    // s1 granted last, then reset: pointer must return to port 2 so s1 wins
    rd1(9'h010);
    @(posedge clk); #1;
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rd1(9'h010); rd2(9'h020);
    #1;
    chk("post-reset tie wait1", 32'(s1_waitrequest), 32'd0);
    chk("post-reset tie wait2", 32'(s2_waitrequest), 32'd1);
    @(posedge clk); #1;
    idle();
    repeat (3) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
